// File: rtl/pwm_duty_ramp.sv
// Triangle "breathing" duty sequencer for a PWM stage; O_duty/O_step_stb register one cycle after each step tick.
// No backpressure: I_en low freezes timer and ramp, I_restart returns to duty 0 with priority over everything.
module pwm_duty_ramp #(
    parameter int STEP_CYCLES = 1_000_000,
    parameter int HOLD_STEPS  = 0,
    parameter int MAX_DUTY    = 100
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic       I_en,
    input  logic       I_restart,
    input  logic [7:0] I_peak,
    output logic [7:0] O_duty,
    output logic       O_step_stb,
    output logic       O_dir
);

    localparam int TMR_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_CYCLES - 1);
    localparam logic [7:0] MAX_D = 8'(MAX_DUTY);
    localparam logic [7:0] HOLD_D = 8'(HOLD_STEPS);

    typedef enum logic [1:0] {
        ST_RISE    = 2'd0,
        ST_HOLD_HI = 2'd1,
        ST_FALL    = 2'd2,
        ST_HOLD_LO = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         duty_q, duty_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               step_stb_q, step_stb_d;

    logic               tick;
    logic [7:0]         peak_eff;
    logic [7:0]         duty_inc;
    logic [7:0]         duty_dec;

    always_comb begin
        peak_eff = (I_peak > MAX_D) ? MAX_D : I_peak;
        duty_inc = duty_q + 8'd1;
        duty_dec = duty_q - 8'd1;
        tick     = I_en && (timer_q == TMR_LAST);
    end

    // Timer freezes (not clears) while paused so a resume finishes the partial step.
    always_comb begin
        timer_d    = timer_q;
        step_stb_d = 1'b0;
        if (I_restart) begin
            timer_d = '0;
        end else if (I_en) begin
            timer_d    = tick ? '0 : timer_q + TMR_W'(1);
            step_stb_d = tick;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= ST_RISE;
            duty_q     <= '0;
            hold_cnt_q <= '0;
            timer_q    <= '0;
            step_stb_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            hold_cnt_q <= hold_cnt_d;
            timer_q    <= timer_d;
            step_stb_q <= step_stb_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        hold_cnt_d = hold_cnt_q;
        if (I_restart) begin
            state_d    = ST_RISE;
            duty_d     = '0;
            hold_cnt_d = '0;
        end else if (tick) begin
            unique case (state_q)
                ST_RISE: begin
                    if (peak_eff == 8'd0) begin
                        duty_d  = '0;
                        state_d = ST_HOLD_LO;
                    end else if (duty_q < peak_eff) begin
                        duty_d = duty_inc;
                        if (duty_inc == peak_eff) begin
                            state_d = ST_HOLD_HI;
                        end
                    end else begin
                        // Peak was lowered below the current duty: snap down to it.
                        duty_d  = peak_eff;
                        state_d = ST_HOLD_HI;
                    end
                end
                ST_HOLD_HI: begin
                    if (hold_cnt_q < HOLD_D) begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end else begin
                        hold_cnt_d = '0;
                        if (duty_q == 8'd0) begin
                            state_d = ST_HOLD_LO;
                        end else begin
                            duty_d  = duty_dec;
                            state_d = (duty_dec == 8'd0) ? ST_HOLD_LO : ST_FALL;
                        end
                    end
                end
                ST_FALL: begin
                    if (duty_q == 8'd0) begin
                        state_d = ST_HOLD_LO;
                    end else begin
                        duty_d = duty_dec;
                        if (duty_dec == 8'd0) begin
                            state_d = ST_HOLD_LO;
                        end
                    end
                end
                ST_HOLD_LO: begin
                    if (hold_cnt_q < HOLD_D) begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end else if (peak_eff != 8'd0) begin
                        hold_cnt_d = '0;
                        duty_d     = 8'd1;
                        state_d    = (peak_eff == 8'd1) ? ST_HOLD_HI : ST_RISE;
                    end
                end
                default: begin
                    state_d = ST_RISE;
                end
            endcase
        end
    end

    always_comb begin
        O_dir = (state_q == ST_HOLD_HI) || (state_q == ST_FALL);
    end

    assign O_duty     = duty_q;
    assign O_step_stb = step_stb_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: two instances (HOLD_STEPS 0 and 1, STEP_CYCLES 4) sharing stimulus;
// expected duty/dir per step tick queued up front and popped on each O_step_stb.
module tb_pwm_duty_ramp;

    localparam int STEP = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       restart;
    logic [7:0] peak;
    logic [7:0] duty0, duty1;
    logic       stb0, stb1;
    logic       dir0, dir1;

    typedef struct packed {
        logic [7:0] duty;
        logic       dir;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    pwm_duty_ramp #(.STEP_CYCLES(STEP), .HOLD_STEPS(0), .MAX_DUTY(100)) u_dut0 (
        .I_clk(clk), .I_rst_n(rst_n), .I_en(en), .I_restart(restart), .I_peak(peak),
        .O_duty(duty0), .O_step_stb(stb0), .O_dir(dir0)
    );

    pwm_duty_ramp #(.STEP_CYCLES(STEP), .HOLD_STEPS(1), .MAX_DUTY(100)) u_dut1 (
        .I_clk(clk), .I_rst_n(rst_n), .I_en(en), .I_restart(restart), .I_peak(peak),
        .O_duty(duty1), .O_step_stb(stb1), .O_dir(dir1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push(input int d, input bit dir);
        exp_t e;
        e.duty = 8'(d);
        e.dir  = dir;
        exp_q.push_back(e);
    endtask

    task automatic wait_stb(input bit sel, input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (!ok && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if ((sel ? stb1 : stb0) === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; restart = 1'b0; peak = 8'd3;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({duty0, stb0, dir0} !== 10'd0) $display("FAIL reset_dut0: got duty=%0d stb=%0b dir=%0b, expected 0 0 0", duty0, stb0, dir0);
        else n_pass++;
        n_checks++;
        if ({duty1, stb1, dir1} !== 10'd0) $display("FAIL reset_dut1: got duty=%0d stb=%0b dir=%0b, expected 0 0 0", duty1, stb1, dir1);
        else n_pass++;
    endtask

    task automatic test_basic();
        exp_t e;
        int   c;
        bit   ok;
        int   k;
        en = 1'b1; peak = 8'd3;
        push(1, 0); push(2, 0); push(3, 1); push(2, 1); push(1, 1);
        push(0, 0); push(1, 0); push(2, 0); push(3, 1); push(2, 1);
        rst_n = 1'b1;
        k = 0;
        while (exp_q.size() > 0) begin
            wait_stb(1'b0, 20, c, ok);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok) begin
                $display("FAIL basic_timeout step %0d: no strobe in 20 clocks, expected duty=%0d", k, e.duty);
                exp_q.delete();
            end else if ({duty0, dir0} !== e) begin
                $display("FAIL basic_seq step %0d: got duty=%0d dir=%0b, expected duty=%0d dir=%0b", k, duty0, dir0, e.duty, e.dir);
            end else n_pass++;
            if (ok) begin
                n_checks++;
                if (c !== STEP) $display("FAIL basic_spacing step %0d: got %0d clocks, expected %0d", k, c, STEP);
                else n_pass++;
            end
            k++;
        end
    endtask

    task automatic test_hold_clamp();
        exp_t e;
        int   c;
        bit   ok;
        int   k;
        int   maxd;
        peak = 8'd200;
        do_restart();
        for (int d = 1; d <= 100; d++) push(d, d == 100);
        push(100, 1);
        for (int d = 99; d >= 0; d--) push(d, d != 0);
        push(0, 0);
        push(1, 0);
        k = 0; maxd = 0;
        while (exp_q.size() > 0) begin
            wait_stb(1'b1, 20, c, ok);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok) begin
                $display("FAIL hold_timeout step %0d: no strobe in 20 clocks, expected duty=%0d", k, e.duty);
                exp_q.delete();
            end else if ({duty1, dir1} !== e) begin
                $display("FAIL hold_seq step %0d: got duty=%0d dir=%0b, expected duty=%0d dir=%0b", k, duty1, dir1, e.duty, e.dir);
            end else n_pass++;
            if (ok && int'(duty1) > maxd) maxd = int'(duty1);
            k++;
        end
        n_checks++;
        if (maxd !== 100) $display("FAIL hold_max: got peak duty %0d, expected 100", maxd);
        else n_pass++;
    endtask

    task automatic test_pause();
        exp_t e;
        int   c;
        bit   ok;
        int   k;
        peak = 8'd100;
        do_restart();
        for (int d = 1; d <= 37; d++) push(d, 0);
        k = 0;
        while (exp_q.size() > 0) begin
            wait_stb(1'b0, 20, c, ok);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok) begin
                $display("FAIL pause_timeout step %0d: no strobe in 20 clocks, expected duty=%0d", k, e.duty);
                exp_q.delete();
            end else if ({duty0, dir0} !== e) begin
                $display("FAIL pause_rise step %0d: got duty=%0d dir=%0b, expected duty=%0d dir=%0b", k, duty0, dir0, e.duty, e.dir);
            end else n_pass++;
            k++;
        end
        repeat (2) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({duty0, stb0} !== {8'd37, 1'b0}) $display("FAIL pause_frozen cycle %0d: got duty=%0d stb=%0b, expected 37 0", i, duty0, stb0);
            else n_pass++;
        end
        en = 1'b1;
        wait_stb(1'b0, 20, c, ok);
        n_checks++;
        if (!ok || c !== 2) $display("FAIL pause_resume_latency: got ok=%0b clocks=%0d, expected 2", ok, c);
        else n_pass++;
        n_checks++;
        if (duty0 !== 8'd38) $display("FAIL pause_resume_duty: got %0d, expected 38", duty0);
        else n_pass++;
    endtask

    task automatic test_restart();
        exp_t e;
        int   c;
        bit   ok;
        int   k;
        for (int d = 39; d <= 100; d++) push(d, d == 100);
        for (int d = 99; d >= 60; d--) push(d, 1);
        k = 0;
        while (exp_q.size() > 0) begin
            wait_stb(1'b0, 20, c, ok);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok) begin
                $display("FAIL restart_timeout step %0d: no strobe in 20 clocks, expected duty=%0d", k, e.duty);
                exp_q.delete();
            end else if ({duty0, dir0} !== e) begin
                $display("FAIL restart_ramp step %0d: got duty=%0d dir=%0b, expected duty=%0d dir=%0b", k, duty0, dir0, e.duty, e.dir);
            end else n_pass++;
            k++;
        end
        // Timer is now 0; three more clocks puts the next cycle on a tick.
        repeat (3) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        n_checks++;
        if ({duty0, dir0, stb0} !== 10'd0) $display("FAIL restart_on_tick: got duty=%0d dir=%0b stb=%0b, expected 0 0 0", duty0, dir0, stb0);
        else n_pass++;
        wait_stb(1'b0, 20, c, ok);
        n_checks++;
        if (!ok || c !== STEP || duty0 !== 8'd1) $display("FAIL restart_first_tick: got ok=%0b clocks=%0d duty=%0d, expected 1 %0d 1", ok, c, duty0, STEP);
        else n_pass++;
        @(negedge clk);
        en = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        en = 1'b1;
        n_checks++;
        if ({duty0, dir0, stb0} !== 10'd0) $display("FAIL restart_paused: got duty=%0d dir=%0b stb=%0b, expected 0 0 0", duty0, dir0, stb0);
        else n_pass++;
        wait_stb(1'b0, 20, c, ok);
        n_checks++;
        if (!ok || c !== STEP || duty0 !== 8'd1) $display("FAIL restart_paused_tick: got ok=%0b clocks=%0d duty=%0d, expected 1 %0d 1", ok, c, duty0, STEP);
        else n_pass++;
    endtask

    task automatic test_peak_change();
        exp_t e;
        int   c;
        bit   ok;
        int   k;
        peak = 8'd100;
        do_restart();
        for (int phase = 0; phase < 4; phase++) begin
            case (phase)
                0: for (int d = 1; d <= 50; d++) push(d, 0);
                1: begin
                    peak = 8'd20;
                    push(20, 1);
                    for (int d = 19; d >= 1; d--) push(d, 1);
                    push(0, 0);
                end
                2: begin
                    peak = 8'd0;
                    push(0, 0); push(0, 0); push(0, 0);
                end
                default: begin
                    peak = 8'd5;
                    for (int d = 1; d <= 4; d++) push(d, 0);
                    push(5, 1);
                    push(4, 1);
                end
            endcase
            k = 0;
            while (exp_q.size() > 0) begin
                wait_stb(1'b0, 20, c, ok);
                e = exp_q.pop_front();
                n_checks++;
                if (!ok) begin
                    $display("FAIL peak_timeout phase %0d step %0d: no strobe in 20 clocks, expected duty=%0d", phase, k, e.duty);
                    exp_q.delete();
                end else if ({duty0, dir0} !== e) begin
                    $display("FAIL peak_seq phase %0d step %0d: got duty=%0d dir=%0b, expected duty=%0d dir=%0b",
                             phase, k, duty0, dir0, e.duty, e.dir);
                end else n_pass++;
                k++;
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        int   c;
        bit   ok;
        int   k;
        peak = 8'd100;
        do_restart();
        for (int d = 1; d <= 42; d++) push(d, 0);
        k = 0;
        while (exp_q.size() > 0) begin
            wait_stb(1'b0, 20, c, ok);
            e = exp_q.pop_front();
            n_checks++;
            if (!ok) begin
                $display("FAIL arst_timeout step %0d: no strobe in 20 clocks, expected duty=%0d", k, e.duty);
                exp_q.delete();
            end else if ({duty0, dir0} !== e) begin
                $display("FAIL arst_rise step %0d: got duty=%0d dir=%0b, expected duty=%0d dir=%0b", k, duty0, dir0, e.duty, e.dir);
            end else n_pass++;
            k++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({duty0, stb0, dir0} !== 10'd0) $display("FAIL arst_immediate: got duty=%0d stb=%0b dir=%0b, expected 0 0 0", duty0, stb0, dir0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_clamp();
        test_pause();
        test_restart();
        test_peak_change();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
Duty-cycle sequencer that sits directly upstream of the PWM generator and drives its 8-bit 0-100 duty input.
- Produces a triangle ("breathing") duty profile: 0 → peak → 0.
- Duty changes by one unit per programmable step period.
- Programmable dwell at each extreme.
- Runtime-adjustable peak, enable/pause, and synchronous restart.
- Replaces stimulus-driven ramps with synthesizable logic for on-board LED/motor soft-ramping.

Parameters:
STEP_CYCLES, 1_000_000, clock cycles per duty step (10 ms at 100 MHz); legal range ≥1.
HOLD_STEPS, 0, extra step periods held at each extreme (0..255).
MAX_DUTY, 100, absolute duty ceiling; I_peak is clamped to this.

Ports:
I_clk  in  1  system clock (100 MHz nominal)
I_rst_n  in  1  reset, asynchronous, active-low
I_en  in  1  ramp enable, active high; low = pause
I_restart  in  1  synchronous restart pulse, active high
I_peak  in  8  requested peak duty; effective P = min(I_peak, MAX_DUTY)
O_duty  out  8  duty to PWM stage, range 0..P
O_step_stb  out  1  one-cycle pulse on every step tick
O_dir  out  1  0 = rising phase (RISE, HOLD_LO), 1 = falling phase (HOLD_HI, FALL)

Behaviour:
Reset (async assert, sync release):
- O_duty=0, O_step_stb=0, O_dir=0.
- State RISE, step timer=0, hold counter=0.

Step timer and tick:
- Timer counts 0..STEP_CYCLES-1 while I_en=1, then wraps to 0.
- tick = timer at STEP_CYCLES-1 with I_en=1.
- O_step_stb is registered and high for exactly the cycle after the tick edge, i.e. aligned with the updated O_duty.
- P is sampled at the tick only.

State machine (all transitions on tick only):
- RISE:
  - P==0 → duty=0, go HOLD_LO.
  - duty<P → duty+1; if the new duty==P, go HOLD_HI.
  - duty≥P (peak lowered mid-rise) → duty=P, go HOLD_HI.
- HOLD_HI:
  - hold_cnt<HOLD_STEPS → hold_cnt+1.
  - otherwise → hold_cnt=0. If duty==0 go HOLD_LO; else duty-1, go FALL (if the new duty==0, go HOLD_LO instead).
- FALL:
  - duty-1; if the new duty==0, go HOLD_LO.
  - Duty above a lowered P keeps decrementing normally.
- HOLD_LO:
  - hold_cnt<HOLD_STEPS → hold_cnt+1.
  - otherwise, if P==0, stay with hold_cnt saturated.
  - otherwise → hold_cnt=0, duty=1, go RISE (if P==1, go HOLD_HI).

Resulting sequence:
- Each extreme is held HOLD_STEPS+1 step periods.
- Steady-state period = (2·P + 2·HOLD_STEPS) steps.
- Duty never underflows below 0 and never exceeds MAX_DUTY.

I_en=0:
- Timer, state, duty and hold_cnt all frozen.
- No strobes.
- Resuming continues from the frozen timer value.

I_restart=1 (priority over I_en and tick):
- duty=0, state RISE, timer=0, hold_cnt=0.
- O_step_stb=0 that cycle.

Counter widths:
- Timer width is sized from STEP_CYCLES.
- I_peak>MAX_DUTY is treated as MAX_DUTY (e.g. 255 → 100).

Test Plan:
- Reset/basic (STEP_CYCLES=4, HOLD_STEPS=0, I_peak=3): release reset → O_duty sequence 0,1,2,3,2,1,0,1…, one change every 4 clocks; O_step_stb pulses every 4th clock; O_dir=1 while duty is 3 and during the falls.
- Hold and clamp (HOLD_STEPS=1, I_peak=200): duty reaches 100 and is never above it; 100 and 0 each persist 2 step periods; full period = 200+2 = 202 steps.
- Pause (I_peak=100): drop I_en for 10 clocks mid-rise at duty=37 → duty stays 37, no strobes; after re-enable the next tick arrives after the remaining timer cycles, and duty becomes 38.
- Restart mid-fall at duty=60 (assert I_restart together with I_en=0 and on a tick cycle) → next cycle duty=0, O_dir=0, no strobe; first subsequent tick yields duty=1.
- Peak changes:
  - Lower I_peak from 100 to 20 while rising at duty=50 → next tick duty=20, HOLD_HI, then falls to 0.
  - Set I_peak=0 → duty settles at 0 and stays there.
  - Restore I_peak=5 → rise resumes 1..5.
- Async reset mid-ramp at duty=42 (assert I_rst_n=0 between clock edges) → O_duty=0, O_step_stb=0, O_dir=0 immediately, without waiting for a clock edge.
